// File: rtl/bank_match_sched.sv
// -----------------------------------------------------------------------------
// bank_match_sched
//
// Sequencing controller for the shared four-bank field comparator. Four
// requesters each present a key. One requester is granted round-robin, and its
// key is latched. The 2-bit bank select then walks banks 0..3, and each
// selected bank field is compared against the latched key. When the walk ends,
// the block pulses `done` and reports the match results.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   per-requester request, held until done (dropping it aborts)
//   key        requester i key at [i*W +: W], sampled once at grant
//   bank_data  field of the bank addressed by bank_sel (same-cycle datapath)
//   bank_sel   registered bank select driven to the datapath mux
//   grant      one-hot grant, high through SCAN and DONE
//   busy       high in SCAN and DONE
//   done       one-cycle completion pulse
//   hit        any bank matched (valid with done)
//   hit_vec    per-bank match vector (valid with done)
//   hit_bank   lowest matching bank, 0 if none (valid with done)
//
// Build option:
//   BMS_EARLY_EXIT_EN  when defined, the scan ends on the first matching bank.
//                      When undefined, all four banks are always scanned.
// -----------------------------------------------------------------------------
module bank_match_sched #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] key,
  input  logic [W-1:0]   bank_data,
  output logic [1:0]     bank_sel,
  output logic [3:0]     grant,
  output logic           busy,
  output logic           done,
  output logic           hit,
  output logic [3:0]     hit_vec,
  output logic [1:0]     hit_bank
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   bank_sel_q, bank_sel_d;
  logic [3:0]   grant_q, grant_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         hit_q, hit_d;
  logic [3:0]   hit_vec_q, hit_vec_d;
  logic [1:0]   hit_bank_q, hit_bank_d;
  logic [1:0]   last_q, last_d;
  logic [W-1:0] key_q, key_d;

  // Unpacked view of the key bus, and the request vector rotated so that
  // rot_req[i] belongs to requester (last + 1 + i) mod 4.
  logic [W-1:0] key_arr [4];
  logic [3:0]   rot_req;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign key_arr[gi] = key[gi*W +: W];
      assign rot_req[gi] = req[last_q + 2'(gi + 1)];
    end
  endgenerate

  // The first set bit of the rotated vector is the round-robin winner.
  logic       pick_valid;
  logic [1:0] pick_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = last_q + 2'(i + 1);
      end
    end
  end

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (v[b]) r = 2'(b);
    end
    return r;
  endfunction

  logic owner_req;
  logic match;
  logic scan_end;

  assign owner_req = |(req & grant_q);
  assign match     = (bank_data == key_q);

  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    hit_vec_d  = hit_vec_q;
    hit_bank_d = hit_bank_q;
    last_d     = last_q;
    key_d      = key_q;
    scan_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          key_d      = key_arr[pick_idx];
          grant_d    = 4'b0001 << pick_idx;
          last_d     = pick_idx;
          hit_vec_d  = 4'b0000;
          hit_d      = 1'b0;
          hit_bank_d = 2'd0;
          bank_sel_d = 2'd0;
          busy_d     = 1'b1;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (!owner_req) begin
          // Abort: the owner dropped its request. Leave without a done pulse.
          // The round-robin pointer keeps the aborted index.
          state_d    = IDLE;
          grant_d    = 4'b0000;
          busy_d     = 1'b0;
          bank_sel_d = 2'd0;
          hit_vec_d  = 4'b0000;
        end else begin
          hit_vec_d[bank_sel_q] = match;
`ifdef BMS_EARLY_EXIT_EN
          scan_end = match || (bank_sel_q == 2'd3);
`else
          scan_end = (bank_sel_q == 2'd3);
`endif
          if (scan_end) begin
            // Summaries come from the vector including this cycle's compare,
            // so they are already valid when done rises.
            state_d    = DONE;
            done_d     = 1'b1;
            hit_d      = |hit_vec_d;
            hit_bank_d = lowest_set(hit_vec_d);
          end else begin
            bank_sel_d = bank_sel_q + 2'd1;
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        busy_d     = 1'b0;
        bank_sel_d = 2'd0;
      end

      default: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        busy_d     = 1'b0;
        bank_sel_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bank_sel_q <= 2'd0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_vec_q  <= 4'b0000;
      hit_bank_q <= 2'd0;
      last_q     <= 2'd3;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      hit_vec_q  <= hit_vec_d;
      hit_bank_q <= hit_bank_d;
      last_q     <= last_d;
      key_q      <= key_d;
    end
  end

  assign bank_sel = bank_sel_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign hit_vec  = hit_vec_q;
  assign hit_bank = hit_bank_q;

endmodule

// File: tb/tb_bank_match_sched.sv
// -----------------------------------------------------------------------------
// tb_bank_match_sched
//
// Bench for bank_match_sched. The bench holds the four bank fields, and
// bank_data is driven from them by the DUT's bank_sel.
//
// The transaction model works from whole-array compares: at grant it computes
// the full match vector and the scan length. A compare process then checks the
// DUT outputs against the model on every falling edge. Directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bank_match_sched;
  localparam int W = 8;
`ifdef BMS_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] key;
  logic [W-1:0]   bank_data;
  logic [1:0]     bank_sel;
  logic [3:0]     grant;
  logic           busy, done, hit;
  logic [3:0]     hit_vec;
  logic [1:0]     hit_bank;

  logic [W-1:0] banks [4];

  bank_match_sched #(.W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .key(key), .bank_data(bank_data),
    .bank_sel(bank_sel), .grant(grant), .busy(busy), .done(done),
    .hit(hit), .hit_vec(hit_vec), .hit_bank(hit_bank)
  );

  always #5 clk = ~clk;
  assign bank_data = banks[bank_sel];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int b = 3; b >= 0; b--) if (v[b]) r = 2'(b);
    return r;
  endfunction

  // ---------------- transaction model ----------------
  logic [3:0] e_grant, e_vec, m_vec;
  logic [1:0] e_sel, e_bank;
  logic       e_busy, e_done, e_hit;
  int         m_last, m_owner, m_age, m_len;

  always @(posedge clk) begin : model
    int         pick;
    int         first;
    logic [3:0] fv;
    logic [W-1:0] k;
    if (rst) begin
      e_grant <= 4'd0; e_sel <= 2'd0; e_busy <= 1'b0; e_done <= 1'b0;
      e_hit <= 1'b0; e_vec <= 4'd0; e_bank <= 2'd0;
      m_last <= 3; m_owner <= -1; m_age <= 0; m_len <= 0; m_vec <= 4'd0;
    end else if (e_done) begin
      e_done <= 1'b0; e_grant <= 4'd0; e_busy <= 1'b0; e_sel <= 2'd0;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int o = 1; o <= 4; o++)
        if (pick < 0 && req[(m_last + o) % 4]) pick = (m_last + o) % 4;
      if (pick >= 0) begin
        k = key[pick*W +: W];
        for (int b = 0; b < 4; b++) fv[b] = (banks[b] == k);
        first = -1;
        for (int b = 3; b >= 0; b--) if (fv[b]) first = b;
        if (EARLY && first >= 0) begin
          m_len <= first + 1;
          m_vec <= 4'b0001 << first;
        end else begin
          m_len <= 4;
          m_vec <= fv;
        end
        m_owner <= pick; m_last <= pick; m_age <= 1;
        e_grant <= 4'b0001 << pick; e_busy <= 1'b1; e_sel <= 2'd0;
      end
    end else begin
      if (!req[m_owner]) begin
        e_grant <= 4'd0; e_busy <= 1'b0; e_sel <= 2'd0; m_owner <= -1;
      end else if (m_age == m_len) begin
        e_done <= 1'b1; e_hit <= |m_vec; e_vec <= m_vec; e_bank <= lowest(m_vec);
        m_owner <= -1;
      end else begin
        e_sel <= e_sel + 2'd1; m_age <= m_age + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("grant", grant, e_grant);
      chk("bank_sel", bank_sel, e_sel);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_done) begin
        chk("hit", hit, e_hit);
        chk("hit_vec", hit_vec, e_vec);
        chk("hit_bank", hit_bank, e_bank);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_banks(input logic [W-1:0] b0, b1, b2, b3);
    banks[0] = b0; banks[1] = b1; banks[2] = b2; banks[3] = b3;
  endtask

  task automatic do_reset();
    req = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for a fresh grant, then count cycles from the first grant cycle until done.
  task automatic wait_txn(output logic [3:0] g, output int lat);
    int n;
    n = 0;
    while (grant != 4'd0 && n < 20) begin @(negedge clk); n++; end
    while (grant == 4'd0 && n < 40) begin @(negedge clk); n++; end
    chk("grant_seen", 32'(grant != 4'd0), 1);
    g = grant;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_scan_at(input logic [1:0] sel);
    int n;
    n = 0;
    while ((grant == 4'd0 || bank_sel != sel) && n < 30) begin @(negedge clk); n++; end
    chk("scan_reached", bank_sel, sel);
  endtask

  logic [3:0] g;
  int         lat;
  logic [3:0] rr_exp [5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    key = '0;
    set_banks(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    cmp_en = 1'b1;
    // Reset state
    chk("rst_grant", grant, 4'd0);
    chk("rst_bank_sel", bank_sel, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hit_vec", hit_vec, 4'd0);
    chk("rst_hit_bank", hit_bank, 2'd0);

    // Single request, match at bank 2 only
    set_banks(8'h00, 8'h11, 8'hA5, 8'h22);
    key[0*W +: W] = 8'hA5;
    req = 4'b0001;
    wait_txn(g, lat);
    chk("t1_grant", g, 4'b0001);
    chk("t1_latency", lat, EARLY ? 3 : 4);
    chk("t1_hit", hit, 1'b1);
    chk("t1_hit_vec", hit_vec, 4'b0100);
    chk("t1_hit_bank", hit_bank, 2'd2);
    req = 4'd0;
    repeat (2) @(negedge clk);

    // Multi-match on banks 1 and 3
    set_banks(8'h00, 8'h3C, 8'h11, 8'h3C);
    key[2*W +: W] = 8'h3C;
    req = 4'b0100;
    wait_txn(g, lat);
    chk("t2_grant", g, 4'b0100);
    chk("t2_latency", lat, EARLY ? 2 : 4);
    chk("t2_hit_vec", hit_vec, EARLY ? 4'b0010 : 4'b1010);
    chk("t2_hit_bank", hit_bank, 2'd1);
    req = 4'd0;
    repeat (2) @(negedge clk);

    // No match
    set_banks(8'h00, 8'h01, 8'h02, 8'h03);
    key[1*W +: W] = 8'hFF;
    req = 4'b0010;
    wait_txn(g, lat);
    chk("t3_latency", lat, 4);
    chk("t3_hit", hit, 1'b0);
    chk("t3_hit_vec", hit_vec, 4'd0);
    chk("t3_hit_bank", hit_bank, 2'd0);
    req = 4'd0;
    repeat (2) @(negedge clk);

    // Round-robin with all requests held, starting from reset
    do_reset();
    key = {8'h03, 8'h02, 8'h01, 8'h00};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_txn(g, lat);
      chk($sformatf("rr_grant%0d", t), g, rr_exp[t]);
    end
    req = 4'd0;
    repeat (3) @(negedge clk);

    // Abort: req0 drops while bank_sel=1, pending req1 granted two cycles later
    do_reset();
    set_banks(8'h00, 8'h01, 8'h02, 8'h03);
    key[0*W +: W] = 8'hAA;
    key[1*W +: W] = 8'hAA;
    req = 4'b0011;
    wait_scan_at(2'd1);
    chk("ab_grant0", grant, 4'b0001);
    req = 4'b0010;
    @(negedge clk);
    chk("ab_idle_busy", busy, 1'b0);
    chk("ab_idle_grant", grant, 4'd0);
    chk("ab_idle_done", done, 1'b0);
    @(negedge clk);
    chk("ab_grant1", grant, 4'b0010);
    req = 4'd0;
    repeat (3) @(negedge clk);

    // Mid-scan reset at bank_sel=2
    req = 4'b0100;
    wait_scan_at(2'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_grant", grant, 4'd0);
    chk("mr_bank_sel", bank_sel, 2'd0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    rst = 1'b0;
    req = 4'b1111;
    wait_txn(g, lat);
    chk("mr_first_grant", g, 4'b0001);
    req = 4'd0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
